// File: rtl/spi_arb_pkg.sv
// spi_arb_pkg: spi register map and arbiter state encoding shared
// by the arbiter and its selector.
package spi_arb_pkg;

    localparam logic [4:0] SPI_DR   = 5'h00;
    localparam logic [4:0] SPI_CS_V = 5'h04;

    typedef enum logic [2:0] {
        IDLE,
        CS_WR,
        DR_WR,
        WAIT,
        DR_RD,
        CS_CLR
    } spi_arb_state_e;

    // A zero wait request still waits one cycle.
    function automatic logic [15:0] wait_len(input logic [15:0] c);
        return (c == 16'd0) ? 16'd1 : c;
    endfunction

endpackage

// File: rtl/spi_arb_sel.sv
// spi_arb_sel: one-hot winner from a request vector.
// SPI_ARB_RR_EN: round-robin from i_ptr; otherwise lowest index wins.
module spi_arb_sel #(
    parameter int n_req = 2,
    parameter int ptr_w = (n_req > 1) ? $clog2(n_req) : 1
) (
    input  logic [n_req-1:0] i_req,
    input  logic [ptr_w-1:0] i_ptr,
    output logic [n_req-1:0] o_gnt
);

`ifdef SPI_ARB_RR_EN
    // Scan offsets far-to-near so the one nearest i_ptr wins.
    always_comb begin
        o_gnt = '0;
        for (int k = n_req - 1; k >= 0; k--) begin
            for (int j = 0; j < n_req; j++) begin
                if (j == (int'(i_ptr) + k) % n_req && i_req[j]) begin
                    o_gnt    = '0;
                    o_gnt[j] = 1'b1;
                end
            end
        end
    end
`else
    logic w_unused_ptr;
    assign w_unused_ptr = ^i_ptr;

    // Scan high-to-low so the lowest requesting index wins.
    always_comb begin
        o_gnt = '0;
        for (int j = n_req - 1; j >= 0; j--) begin
            if (i_req[j]) begin
                o_gnt    = '0;
                o_gnt[j] = 1'b1;
            end
        end
    end
`endif

endmodule

// File: rtl/spi_arb.sv
// spi_arb: shares one spi register port between n_req requesters.
// Define SPI_ARB_RR_EN for round-robin arbitration (default: fixed priority).
module spi_arb
    import spi_arb_pkg::*;
#(
    parameter int              n_req   = 2,
    parameter int              cs_w    = 8,
    parameter logic [cs_w-1:0] cs_idle = '1
) (
    input  logic                    clk,
    input  logic                    rstn,
    input  logic [n_req-1:0]        req,
    input  logic [n_req*cs_w-1:0]   cs_v_in,
    input  logic [n_req*8-1:0]      tx_data,
    input  logic [n_req-1:0]        tx_last,
    output logic [n_req-1:0]        tx_ack,
    output logic [n_req-1:0]        gnt,
    output logic [7:0]              rx_data,
    output logic [n_req-1:0]        rx_vld,
    output logic                    busy,
    input  logic [15:0]             xfer_cyc,
    output logic [4:0]              addr,
    output logic                    re,
    output logic                    we,
    output logic [31:0]             wd,
    input  logic [31:0]             rd
);

    localparam int PW = (n_req > 1) ? $clog2(n_req) : 1;

    spi_arb_state_e    r_st;
    spi_arb_state_e    w_nst;
    logic [n_req-1:0]  r_gnt;
    logic [n_req-1:0]  r_vld;
    logic [n_req-1:0]  w_win;
    logic [7:0]        r_rx;
    logic [15:0]       r_cnt;
    logic              r_last;
    logic [PW-1:0]     w_ptr;
    logic [cs_w-1:0]   w_cs;
    logic [7:0]        w_tx;
    logic              w_last_in;
    logic              w_unused_rd;

    assign w_unused_rd = ^rd[31:8];

    spi_arb_sel #(
        .n_req (n_req),
        .ptr_w (PW)
    ) u_sel (
        .i_req (req),
        .i_ptr (w_ptr),
        .o_gnt (w_win)
    );

`ifdef SPI_ARB_RR_EN
    logic [PW-1:0] r_ptr;
    logic [PW-1:0] w_nxt;

    // Next search start: one past the requester being released.
    always_comb begin
        w_nxt = '0;
        for (int j = 0; j < n_req; j++) begin
            if (r_gnt[j]) w_nxt = PW'((j + 1) % n_req);
        end
    end

    // Search start advances only when the bus is released.
    always_ff @(posedge clk) begin
        if (!rstn) r_ptr <= '0;
        else if (r_st == CS_CLR) r_ptr <= w_nxt;
    end

    assign w_ptr = r_ptr;
`else
    assign w_ptr = '0;
`endif

    // Pick the granted requester's chip-select, byte and last flag.
    always_comb begin
        w_cs      = '0;
        w_tx      = '0;
        w_last_in = 1'b0;
        for (int j = 0; j < n_req; j++) begin
            if (r_gnt[j]) begin
                w_cs      = cs_v_in[j*cs_w +: cs_w];
                w_tx      = tx_data[j*8 +: 8];
                w_last_in = tx_last[j];
            end
        end
    end

    // Next state and register-bus strobes; bus idles at zero.
    always_comb begin
        w_nst  = r_st;
        re     = 1'b0;
        we     = 1'b0;
        addr   = '0;
        wd     = '0;
        tx_ack = '0;
        unique case (r_st)
            IDLE: begin
                if (|req) w_nst = CS_WR;
            end
            CS_WR: begin
                we             = 1'b1;
                addr           = SPI_CS_V;
                wd[cs_w-1:0]   = w_cs;
                w_nst          = DR_WR;
            end
            DR_WR: begin
                we      = 1'b1;
                addr    = SPI_DR;
                wd[7:0] = w_tx;
                tx_ack  = r_gnt;
                w_nst   = WAIT;
            end
            WAIT: begin
                if (r_cnt <= 16'd1) w_nst = DR_RD;
            end
            DR_RD: begin
                re    = 1'b1;
                addr  = SPI_DR;
                w_nst = r_last ? CS_CLR : DR_WR;
            end
            CS_CLR: begin
                we           = 1'b1;
                addr         = SPI_CS_V;
                wd[cs_w-1:0] = cs_idle;
                w_nst        = IDLE;
            end
            default: w_nst = IDLE;
        endcase
    end

    // State, grant, wait counter and receive capture.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            r_st   <= IDLE;
            r_gnt  <= '0;
            r_vld  <= '0;
            r_rx   <= '0;
            r_cnt  <= '0;
            r_last <= 1'b0;
        end else begin
            r_st  <= w_nst;
            r_vld <= '0;
            if (r_st == IDLE && |req) r_gnt <= w_win;
            if (r_st == CS_CLR) r_gnt <= '0;
            if (r_st == DR_WR) begin
                r_cnt  <= wait_len(xfer_cyc);
                r_last <= w_last_in;
            end else if (r_st == WAIT && r_cnt != 16'd0) begin
                r_cnt <= r_cnt - 16'd1;
            end
            if (r_st == DR_RD) begin
                r_rx  <= rd[7:0];
                r_vld <= r_gnt;
            end
        end
    end

    assign gnt     = r_gnt;
    assign rx_vld  = r_vld;
    assign rx_data = r_rx;
    assign busy    = (r_st != IDLE);

endmodule
